// File: rtl/maxpool_seq_ctrl.sv
// -----------------------------------------------------------------------------
// maxpool_seq_ctrl
// Job sequencer for the streaming max-pool core. Forwards window-ordered
// activation beats from the source to the core, marks the first beat of each
// window (core_start) and the final beat of the job (core_in_last), counts
// beats/windows, then watches the core output handshake to detect completion.
//
// Ports
//   clk, rst_b                 clock, asynchronous active-low reset
//   cfg_wr_en/addr/wdata       config writes: 0x24 WIN_SIZE, 0x25 NUM_WIN,
//                              0x26 CTRL (bit0 go, bit1 abort, self-clearing)
//   src_valid/ready/data       upstream beat stream
//   core_in_valid/ready/data   beat stream into the core
//   core_start, core_in_last   window-start and job-last flags to the core
//   mon_valid/ready/last       taps of the core output handshake
//   busy, done, cfg_err        job status (done/cfg_err are 1-cycle pulses)
//   win_idx, beat_idx          current window / beat position
// -----------------------------------------------------------------------------
module maxpool_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int AXI_WIDTH  = 128,
  parameter int WIN_W      = 7,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 cfg_wr_en,
  input  logic [5:0]           cfg_addr,
  input  logic [63:0]          cfg_wdata,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [AXI_WIDTH-1:0] src_data,
  output logic                 core_in_valid,
  input  logic                 core_in_ready,
  output logic [AXI_WIDTH-1:0] core_in_data,
  output logic                 core_start,
  output logic                 core_in_last,
  input  logic                 mon_valid,
  input  logic                 mon_ready,
  input  logic                 mon_last,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [CNT_W-1:0]     win_idx,
  output logic [WIN_W-1:0]     beat_idx
);

  localparam int LANES = AXI_WIDTH / DATA_WIDTH;
  localparam logic [5:0] ADDR_WIN_SIZE = 6'h24;
  localparam logic [5:0] ADDR_NUM_WIN  = 6'h25;
  localparam logic [5:0] ADDR_CTRL     = 6'h26;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t           r_state, w_nextState;
  logic [WIN_W-1:0] r_winSizeShadow, r_winSize, r_beatIdx, w_nextBeatIdx;
  logic [CNT_W-1:0] r_numWinShadow, r_numWin, r_winIdx, w_nextWinIdx;
  logic             r_done, r_cfgErr, w_nextDone, w_nextCfgErr;
  logic             w_go, w_abort, w_shadowZero, w_goAccept;
  logic             w_run, w_inHs, w_monLastHs, w_beatLast, w_winLast;
  logic             w_unusedWdata;

  // CTRL bits are strobes decoded straight from the write; nothing is stored.
  assign w_go          = cfg_wr_en & (cfg_addr == ADDR_CTRL) & cfg_wdata[0];
  assign w_abort       = cfg_wr_en & (cfg_addr == ADDR_CTRL) & cfg_wdata[1];
  assign w_unusedWdata = ^cfg_wdata;
  assign w_shadowZero  = (r_winSizeShadow == '0) | (r_numWinShadow == '0);
  assign w_goAccept    = (r_state == ST_IDLE) & w_go & ~w_abort & ~w_shadowZero;

  assign w_run       = (r_state == ST_RUN);
  assign w_beatLast  = (r_beatIdx == r_winSize - WIN_W'(1));
  assign w_winLast   = (r_winIdx == r_numWin - CNT_W'(1));
  assign w_inHs      = w_run & src_valid & core_in_ready;
  assign w_monLastHs = mon_valid & mon_ready & mon_last;

  assign core_in_valid = src_valid & w_run;
  assign src_ready     = core_in_ready & w_run;
  assign core_start    = w_run & (r_beatIdx == '0);
  assign core_in_last  = w_run & w_beatLast & w_winLast;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign cfg_err       = r_cfgErr;
  assign win_idx       = r_winIdx;
  assign beat_idx      = r_beatIdx;

  // Data is forwarded untouched, lane by lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign core_in_data[g*DATA_WIDTH +: DATA_WIDTH] = src_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Shadow registers take every write; working copies only load on an
  // accepted go so a running job keeps its geometry.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_winSizeShadow <= WIN_W'(4);
      r_numWinShadow  <= CNT_W'(1);
      r_winSize       <= WIN_W'(4);
      r_numWin        <= CNT_W'(1);
    end else begin
      if (cfg_wr_en && (cfg_addr == ADDR_WIN_SIZE)) r_winSizeShadow <= cfg_wdata[WIN_W-1:0];
      if (cfg_wr_en && (cfg_addr == ADDR_NUM_WIN))  r_numWinShadow  <= cfg_wdata[CNT_W-1:0];
      if (w_goAccept) begin
        r_winSize <= r_winSizeShadow;
        r_numWin  <= r_numWinShadow;
      end
    end
  end

  // State, counters and status pulses.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= ST_IDLE;
      r_beatIdx <= '0;
      r_winIdx  <= '0;
      r_done    <= 1'b0;
      r_cfgErr  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_beatIdx <= w_nextBeatIdx;
      r_winIdx  <= w_nextWinIdx;
      r_done    <= w_nextDone;
      r_cfgErr  <= w_nextCfgErr;
    end
  end

  // Next-state logic. Abort overrides everything; the final accepted beat
  // moves to DRAIN with counters frozen at the last position.
  always_comb begin
    w_nextState   = r_state;
    w_nextBeatIdx = r_beatIdx;
    w_nextWinIdx  = r_winIdx;
    w_nextDone    = 1'b0;
    w_nextCfgErr  = 1'b0;
    if (w_abort) begin
      w_nextState   = ST_IDLE;
      w_nextBeatIdx = '0;
      w_nextWinIdx  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            if (w_shadowZero) begin
              w_nextCfgErr = 1'b1;
            end else begin
              w_nextState   = ST_RUN;
              w_nextBeatIdx = '0;
              w_nextWinIdx  = '0;
            end
          end
        end
        ST_RUN: begin
          if (w_inHs) begin
            if (w_beatLast && w_winLast) begin
              w_nextState = ST_DRAIN;
            end else if (w_beatLast) begin
              w_nextBeatIdx = '0;
              w_nextWinIdx  = r_winIdx + CNT_W'(1);
            end else begin
              w_nextBeatIdx = r_beatIdx + WIN_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_monLastHs) begin
            w_nextState = ST_IDLE;
            w_nextDone  = 1'b1;
          end
        end
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maxpool_seq_ctrl
// Directed bench for maxpool_seq_ctrl. A job-level model (phase + number of
// accepted beats) predicts every output each cycle; recorded handshakes are
// also checked against hand-computed start/last masks.
// -----------------------------------------------------------------------------
module tb_maxpool_seq_ctrl;

  localparam int AXI_WIDTH = 128;

  logic                 clk = 1'b0;
  logic                 rst_b;
  logic                 cfg_wr_en;
  logic [5:0]           cfg_addr;
  logic [63:0]          cfg_wdata;
  logic                 src_valid, src_ready;
  logic [AXI_WIDTH-1:0] src_data;
  logic                 core_in_valid, core_in_ready;
  logic [AXI_WIDTH-1:0] core_in_data;
  logic                 core_start, core_in_last;
  logic                 mon_valid, mon_ready, mon_last;
  logic                 busy, done, cfg_err;
  logic [15:0]          win_idx;
  logic [6:0]           beat_idx;

  int testsRun = 0;
  int testsFailed = 0;
  bit stallMode = 1'b0;
  bit injectWrite = 1'b0;

  int hsData[$];
  bit hsStart[$];
  bit hsLast[$];

  // Job-level model state: phase 0 idle, 1 run, 2 drain; mK = beats accepted
  int mPhase = 0;
  int mK = 0;
  int mWs = 4;
  int mNw = 1;
  int mShWs = 4;
  int mShNw = 1;
  bit mDone = 1'b0;
  bit mErr = 1'b0;
  bit mIdxKnown = 1'b1;
  logic mGo, mAbort;

  always #5 clk = ~clk;

  maxpool_seq_ctrl #(.DATA_WIDTH(8), .AXI_WIDTH(AXI_WIDTH), .WIN_W(7), .CNT_W(16)) dut (
    .clk(clk), .rst_b(rst_b),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
    .core_start(core_start), .core_in_last(core_in_last),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .win_idx(win_idx), .beat_idx(beat_idx)
  );

  assign mGo    = cfg_wr_en && (cfg_addr == 6'h26) && cfg_wdata[0];
  assign mAbort = cfg_wr_en && (cfg_addr == 6'h26) && cfg_wdata[1];

  // Model: a job is WIN_SIZE*NUM_WIN beats; it drains after the last one
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mPhase <= 0; mK <= 0; mWs <= 4; mNw <= 1; mShWs <= 4; mShNw <= 1;
      mDone <= 1'b0; mErr <= 1'b0; mIdxKnown <= 1'b1;
    end else begin
      mDone <= 1'b0;
      mErr  <= 1'b0;
      if (mAbort) begin
        mPhase <= 0; mK <= 0; mIdxKnown <= 1'b1;
      end else if (mPhase == 0) begin
        if (mGo) begin
          if (mShWs == 0 || mShNw == 0) mErr <= 1'b1;
          else begin mPhase <= 1; mK <= 0; mWs <= mShWs; mNw <= mShNw; end
        end
      end else if (mPhase == 1) begin
        if (src_valid && core_in_ready) begin
          if (mK == mWs * mNw - 1) mPhase <= 2;
          else mK <= mK + 1;
        end
      end else if (mon_valid && mon_ready && mon_last) begin
        mPhase <= 0; mDone <= 1'b1; mIdxKnown <= 1'b0;
      end
      if (cfg_wr_en && cfg_addr == 6'h24) mShWs <= int'(cfg_wdata[6:0]);
      if (cfg_wr_en && cfg_addr == 6'h25) mShNw <= int'(cfg_wdata[15:0]);
    end
  end

  // Record every beat the DUT accepts
  always @(posedge clk) begin
    if (rst_b && src_valid && src_ready) begin
      hsData.push_back(int'(core_in_data[31:0]));
      hsStart.push_back(core_start);
      hsLast.push_back(core_in_last);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    checkOutput("busy", 64'(busy), 64'(mPhase != 0));
    checkOutput("srcReady", 64'(src_ready), 64'((mPhase == 1) && core_in_ready));
    checkOutput("coreValid", 64'(core_in_valid), 64'((mPhase == 1) && src_valid));
    checkOutput("coreStart", 64'(core_start), 64'((mPhase == 1) && (mK % mWs == 0)));
    checkOutput("coreLast", 64'(core_in_last), 64'((mPhase == 1) && (mK == mWs * mNw - 1)));
    checkOutput("done", 64'(done), 64'(mDone));
    checkOutput("cfgErr", 64'(cfg_err), 64'(mErr));
    checkOutput("dataLo", core_in_data[63:0], src_data[63:0]);
    checkOutput("dataHi", core_in_data[127:64], src_data[127:64]);
    if (mPhase != 0 || mIdxKnown) begin
      checkOutput("beatIdx", 64'(beat_idx), 64'((mPhase == 0) ? 0 : mK % mWs));
      checkOutput("winIdx", 64'(win_idx), 64'((mPhase == 0) ? 0 : mK / mWs));
    end
  end

  // Advance one cycle; one-shot inputs are cleared, data tracks the beat count
  task automatic applyStimulus();
    int n;
    @(posedge clk);
    #2;
    cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    if (stallMode) begin
      src_valid     = ($urandom_range(0, 3) != 0);
      core_in_ready = ($urandom_range(0, 2) != 0);
    end
    n = hsData.size();
    src_data = {32'(n) ^ 32'h3000_0000, 32'(n) ^ 32'h2000_0000, 32'(n) ^ 32'h1000_0000, 32'(n)};
  endtask

  task automatic cfgWrite(input logic [5:0] addr, input logic [63:0] data);
    cfg_wr_en = 1'b1; cfg_addr = addr; cfg_wdata = data;
    applyStimulus();
  endtask

  task automatic startJob();
    hsData.delete(); hsStart.delete(); hsLast.delete();
    cfgWrite(6'h26, 64'h1);
  endtask

  // Run until the model reaches DRAIN; optionally poke config mid-job
  task automatic runJob();
    int budget = 0;
    bit poked = 1'b0;
    while (mPhase != 2 && budget < 1000) begin
      if (hsData.size() == 3 && !poked) begin
        poked = 1'b1;
        mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
      end
      if (injectWrite && hsData.size() >= 5) begin
        injectWrite = 1'b0;
        cfgWrite(6'h24, 64'd9);
        cfgWrite(6'h26, 64'h1);
      end else begin
        applyStimulus();
      end
      budget++;
    end
    checkOutput("jobReachedDrain", 64'(mPhase == 2), 64'd1);
  endtask

  task automatic finishJob();
    mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
    applyStimulus();
    @(negedge clk);
    checkOutput("donePulseLit", 64'(done), 64'd1);
    checkOutput("busyAfterDoneLit", 64'(busy), 64'd0);
    applyStimulus();
    @(negedge clk);
    checkOutput("doneClearsLit", 64'(done), 64'd0);
  endtask

  // Check recorded beats and return start/last masks for literal pinning
  task automatic checkJob(input int ws, input int expHs, output logic [63:0] startMask,
                          output logic [63:0] lastMask);
    startMask = '0;
    lastMask  = '0;
    checkOutput("hsCount", 64'(hsData.size()), 64'(expHs));
    foreach (hsData[i]) begin
      checkOutput("beatData", 64'(hsData[i]), 64'(i));
      checkOutput("beatStart", 64'(hsStart[i]), 64'(i % ws == 0));
      checkOutput("beatLast", 64'(hsLast[i]), 64'(i == expHs - 1));
      if (i < 64) begin
        startMask[i] = hsStart[i];
        lastMask[i]  = hsLast[i];
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired: %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1);
  end

  initial begin
    logic [63:0] sMask, lMask;
    int budget;
    rst_b = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    src_valid = 1'b1; core_in_ready = 1'b1; src_data = '0;
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    repeat (3) applyStimulus();
    @(negedge clk);
    checkOutput("resetBusyLit", 64'(busy), 64'd0);
    checkOutput("resetReadyLit", 64'(src_ready), 64'd0);
    rst_b = 1'b1;
    applyStimulus();

    // 4-beat windows, 3 windows, no stalls
    cfgWrite(6'h24, 64'd4);
    cfgWrite(6'h25, 64'd3);
    startJob();
    runJob();
    checkJob(4, 12, sMask, lMask);
    checkOutput("startMaskA", sMask, 64'h111);
    checkOutput("lastMaskA", lMask, 64'h800);
    finishJob();

    // Same job with random stalls on both sides
    stallMode = 1'b1;
    startJob();
    runJob();
    stallMode = 1'b0; src_valid = 1'b1; core_in_ready = 1'b1;
    checkJob(4, 12, sMask, lMask);
    checkOutput("startMaskStall", sMask, 64'h111);
    checkOutput("lastMaskStall", lMask, 64'h800);
    finishJob();

    // Zero window size is rejected
    cfgWrite(6'h24, 64'd0);
    cfgWrite(6'h26, 64'h1);
    @(negedge clk);
    checkOutput("cfgErrLit", 64'(cfg_err), 64'd1);
    checkOutput("cfgErrBusyLit", 64'(busy), 64'd0);
    applyStimulus();
    @(negedge clk);
    checkOutput("cfgErrPulseLit", 64'(cfg_err), 64'd0);

    // One-beat windows: start and last coincide on the final beat
    cfgWrite(6'h24, 64'd1);
    cfgWrite(6'h25, 64'd2);
    startJob();
    runJob();
    checkJob(1, 2, sMask, lMask);
    checkOutput("startMaskW1", sMask, 64'h3);
    checkOutput("lastMaskW1", lMask, 64'h2);
    finishJob();

    // Reconfigure while running: current job unaffected, next one uses 9
    cfgWrite(6'h24, 64'd4);
    cfgWrite(6'h25, 64'd3);
    injectWrite = 1'b1;
    startJob();
    runJob();
    checkJob(4, 12, sMask, lMask);
    checkOutput("startMaskKeep", sMask, 64'h111);
    finishJob();
    startJob();
    runJob();
    checkJob(9, 27, sMask, lMask);
    checkOutput("startMaskW9", sMask, 64'h40201);
    checkOutput("lastMaskW9", lMask, 64'h400_0000);
    finishJob();

    // Abort in the second window
    cfgWrite(6'h24, 64'd4);
    startJob();
    budget = 0;
    while (hsData.size() < 5 && budget < 100) begin
      applyStimulus();
      budget++;
    end
    @(negedge clk);
    checkOutput("winBeforeAbortLit", 64'(win_idx), 64'd1);
    cfgWrite(6'h26, 64'h2);
    @(negedge clk);
    checkOutput("abortBusyLit", 64'(busy), 64'd0);
    checkOutput("abortReadyLit", 64'(src_ready), 64'd0);
    checkOutput("abortBeatLit", 64'(beat_idx), 64'd0);
    checkOutput("abortWinLit", 64'(win_idx), 64'd0);
    repeat (3) applyStimulus();
    cfgWrite(6'h26, 64'h3);
    @(negedge clk);
    checkOutput("abortGoBusyLit", 64'(busy), 64'd0);

    // Asynchronous reset while draining, then a normal job
    startJob();
    runJob();
    @(negedge clk);
    #1 rst_b = 1'b0;
    #1;
    checkOutput("asyncBusyLit", 64'(busy), 64'd0);
    checkOutput("asyncValidLit", 64'(core_in_valid), 64'd0);
    checkOutput("asyncReadyLit", 64'(src_ready), 64'd0);
    checkOutput("asyncStartLit", 64'(core_start), 64'd0);
    checkOutput("asyncLastLit", 64'(core_in_last), 64'd0);
    checkOutput("asyncWinLit", 64'(win_idx), 64'd0);
    checkOutput("asyncBeatLit", 64'(beat_idx), 64'd0);
    applyStimulus();
    rst_b = 1'b1;
    applyStimulus();
    cfgWrite(6'h24, 64'd4);
    cfgWrite(6'h25, 64'd3);
    startJob();
    runJob();
    checkJob(4, 12, sMask, lMask);
    checkOutput("startMaskPostRst", sMask, 64'h111);
    finishJob();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
